// File: rtl/execute_stage_if.sv
// Decode-to-execute bundle: operands in, registered execute results and CC state out.
interface execute_stage_if;
  logic        in_valid;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valC;
  logic        out_valid;
  logic [63:0] valE;
  logic        Cnd;
  logic        ZF;
  logic        SF;
  logic        OF;
  logic        instr_err;
  logic        halted;

  modport master (
    output in_valid, icode, ifun, valA, valB, valC,
    input  out_valid, valE, Cnd, ZF, SF, OF, instr_err, halted
  );

  modport slave (
    input  in_valid, icode, ifun, valA, valB, valC,
    output out_valid, valE, Cnd, ZF, SF, OF, instr_err, halted
  );
endinterface

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition evaluation, condition-code register and
// sticky halt state, with all results registered one cycle after acceptance.
module execute_stage #(
  parameter logic [63:0] STACK_STEP = 64'd8,
  parameter logic [2:0]  CC_RESET   = 3'b100
) (
  input logic            clk,
  input logic            reset,
  execute_stage_if.slave bus
);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_XOR = 4'h3
  } alu_fn_e;

  logic        out_valid_q;
  logic [63:0] val_e_q;
  logic        cnd_q;
  logic        zf_q;
  logic        sf_q;
  logic        of_q;
  logic        instr_err_q;
  logic        halted_q;

  logic        accept;
  logic        instr_ok;
  logic        is_opq;
  logic        is_halt;
  logic [63:0] alu_result;
  logic        alu_of;
  logic        cond_eval;
  logic        cnd_next;

  assign accept  = bus.in_valid && !halted_q;
  assign is_opq  = (bus.icode == I_OPQ);
  assign is_halt = (bus.icode == I_HALT);

  // Condition evaluated against the CC state held before this instruction.
  always_comb begin
    cond_eval = 1'b0;
    case (bus.ifun)
      4'h0:    cond_eval = 1'b1;
      4'h1:    cond_eval = (sf_q ^ of_q) | zf_q;
      4'h2:    cond_eval = sf_q ^ of_q;
      4'h3:    cond_eval = zf_q;
      4'h4:    cond_eval = ~zf_q;
      4'h5:    cond_eval = ~(sf_q ^ of_q);
      4'h6:    cond_eval = ~(sf_q ^ of_q) & ~zf_q;
      default: cond_eval = 1'b0;
    endcase
  end

  always_comb begin
    instr_ok   = 1'b1;
    alu_result = 64'd0;
    alu_of     = 1'b0;
    cnd_next   = 1'b0;
    case (bus.icode)
      I_HALT, I_NOP: begin
        instr_ok = (bus.ifun == 4'h0);
      end
      I_RRMOVQ: begin
        instr_ok   = (bus.ifun <= 4'h6);
        alu_result = bus.valA;
        cnd_next   = cond_eval;
      end
      I_IRMOVQ: begin
        instr_ok   = (bus.ifun == 4'h0);
        alu_result = bus.valC;
      end
      I_RMMOVQ, I_MRMOVQ: begin
        instr_ok   = (bus.ifun == 4'h0);
        alu_result = bus.valB + bus.valC;
      end
      I_OPQ: begin
        case (bus.ifun)
          ALU_ADD: begin
            alu_result = bus.valB + bus.valA;
            alu_of     = (bus.valA[63] == bus.valB[63]) && (alu_result[63] != bus.valB[63]);
          end
          ALU_SUB: begin
            alu_result = bus.valB - bus.valA;
            alu_of     = (bus.valA[63] != bus.valB[63]) && (alu_result[63] != bus.valB[63]);
          end
          ALU_AND: alu_result = bus.valB & bus.valA;
          ALU_XOR: alu_result = bus.valB ^ bus.valA;
          default: instr_ok = 1'b0;
        endcase
      end
      I_JXX: begin
        instr_ok = (bus.ifun <= 4'h6);
        cnd_next = cond_eval;
      end
      I_CALL, I_PUSHQ: begin
        instr_ok   = (bus.ifun == 4'h0);
        alu_result = bus.valB - STACK_STEP;
      end
      I_RET, I_POPQ: begin
        instr_ok   = (bus.ifun == 4'h0);
        alu_result = bus.valB + STACK_STEP;
      end
      default: instr_ok = 1'b0;
    endcase
  end

  // Invalid encodings report a zeroed result and halt; CC only moves on a good OPq.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q        <= 1'b0;
      val_e_q            <= 64'd0;
      cnd_q              <= 1'b0;
      {zf_q, sf_q, of_q} <= CC_RESET;
      instr_err_q        <= 1'b0;
      halted_q           <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      if (!instr_ok) begin
        instr_err_q <= 1'b1;
        val_e_q     <= 64'd0;
        cnd_q       <= 1'b0;
        halted_q    <= 1'b1;
      end else begin
        instr_err_q <= 1'b0;
        val_e_q     <= alu_result;
        cnd_q       <= cnd_next;
        if (is_opq) begin
          zf_q <= (alu_result == 64'd0);
          sf_q <= alu_result[63];
          of_q <= alu_of;
        end
        if (is_halt) begin
          halted_q <= 1'b1;
        end
      end
    end else begin
      out_valid_q <= 1'b0;
      instr_err_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.valE      = val_e_q;
  assign bus.Cnd       = cnd_q;
  assign bus.ZF        = zf_q;
  assign bus.SF        = sf_q;
  assign bus.OF        = of_q;
  assign bus.instr_err = instr_err_q;
  assign bus.halted    = halted_q;

endmodule

// File: tb/tb_execute_stage.sv
// Table-driven scoreboard bench for execute_stage: each applied vector queues its
// expected registered outputs, which are popped and compared after the next edge.
module tb_execute_stage;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  execute_stage_if bus();

  execute_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        in_valid;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] va;
    logic [63:0] vb;
    logic [63:0] vc;
    logic        exp_ov;
    logic [63:0] exp_val_e;
    logic        exp_cnd;
    logic [2:0]  exp_cc;
    logic        exp_err;
    logic        exp_halt;
  } vec_t;

  typedef struct {
    string       name;
    logic        ov;
    logic [63:0] val_e;
    logic        cnd;
    logic [2:0]  cc;
    logic        err;
    logic        halt;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic vec_t mk(string n, logic iv, logic [3:0] ic, logic [3:0] fn,
                              logic [63:0] a, logic [63:0] b, logic [63:0] c,
                              logic ov, logic [63:0] e, logic cnd, logic [2:0] cc,
                              logic err, logic h);
    vec_t v;
    v.name = n; v.in_valid = iv; v.icode = ic; v.ifun = fn;
    v.va = a; v.vb = b; v.vc = c;
    v.exp_ov = ov; v.exp_val_e = e; v.exp_cnd = cnd; v.exp_cc = cc;
    v.exp_err = err; v.exp_halt = h;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v, input logic rst);
    exp_t x;
    reset        = rst;
    bus.in_valid = v.in_valid;
    bus.icode    = v.icode;
    bus.ifun     = v.ifun;
    bus.valA     = v.va;
    bus.valB     = v.vb;
    bus.valC     = v.vc;
    x.name = v.name; x.ov = v.exp_ov; x.val_e = v.exp_val_e; x.cnd = v.exp_cnd;
    x.cc = v.exp_cc; x.err = v.exp_err; x.halt = v.exp_halt;
    sb.push_back(x);
  endtask

  task automatic checkOutput();
    exp_t x;
    logic [2:0] cc;
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: got out_valid=%0b, required a queued expectation", bus.out_valid);
      return;
    end
    x  = sb.pop_front();
    cc = {bus.ZF, bus.SF, bus.OF};
    if (bus.out_valid !== x.ov || bus.valE !== x.val_e || bus.Cnd !== x.cnd ||
        cc !== x.cc || bus.instr_err !== x.err || bus.halted !== x.halt) begin
      errors++;
      $display("[TB] FAIL %s: got ov=%0b valE=%h Cnd=%0b ZSO=%03b err=%0b halted=%0b, required ov=%0b valE=%h Cnd=%0b ZSO=%03b err=%0b halted=%0b",
               x.name, bus.out_valid, bus.valE, bus.Cnd, cc, bus.instr_err, bus.halted,
               x.ov, x.val_e, x.cnd, x.cc, x.err, x.halt);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t bad[$];
    checks = 0;
    errors = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.icode    = 4'h0;
    bus.ifun     = 4'h0;
    bus.valA     = '0;
    bus.valB     = '0;
    bus.valC     = '0;

    // name, iv, icode, ifun, valA, valB, valC | ov, valE, Cnd, {ZF,SF,OF}, err, halted
    tbl.push_back(mk("add_5_7",      1, 4'h6, 4'h0, 64'd5, 64'd7, 0,     1, 64'd12, 0, 3'b000, 0, 0));
    tbl.push_back(mk("sub_7_7",      1, 4'h6, 4'h1, 64'd7, 64'd7, 0,     1, 64'd0,  0, 3'b100, 0, 0));
    tbl.push_back(mk("je_taken",     1, 4'h7, 4'h3, 0, 0, 0,             1, 64'd0,  1, 3'b100, 0, 0));
    tbl.push_back(mk("jne_not",      1, 4'h7, 4'h4, 0, 0, 0,             1, 64'd0,  0, 3'b100, 0, 0));
    tbl.push_back(mk("add_ovf",      1, 4'h6, 4'h0, MAXP, MAXP, 0,       1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 3'b011, 0, 0));
    tbl.push_back(mk("jl_not",       1, 4'h7, 4'h2, 0, 0, 0,             1, 64'd0,  0, 3'b011, 0, 0));
    tbl.push_back(mk("cmovge",       1, 4'h2, 4'h5, 64'd9, 0, 0,         1, 64'd9,  1, 3'b011, 0, 0));
    tbl.push_back(mk("pushq",        1, 4'hA, 4'h0, 0, 64'h100, 0,       1, 64'hF8, 0, 3'b011, 0, 0));
    tbl.push_back(mk("popq",         1, 4'hB, 4'h0, 0, 64'hF8, 0,        1, 64'h100,0, 3'b011, 0, 0));
    tbl.push_back(mk("irmovq",       1, 4'h3, 4'h0, 0, 0, 64'd42,        1, 64'd42, 0, 3'b011, 0, 0));
    tbl.push_back(mk("mrmovq",       1, 4'h5, 4'h0, 0, 64'h1000, 64'h20, 1, 64'h1020,0, 3'b011, 0, 0));
    tbl.push_back(mk("rmmovq_wrap",  1, 4'h4, 4'h0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd8, 1, 64'd0, 0, 3'b011, 0, 0));
    tbl.push_back(mk("and_zero",     1, 4'h6, 4'h2, 64'hF0, 64'h0F, 0,   1, 64'd0,  0, 3'b100, 0, 0));
    tbl.push_back(mk("xor_neg",      1, 4'h6, 4'h3, ONES, 64'd0, 0,      1, ONES,   0, 3'b010, 0, 0));
    tbl.push_back(mk("jle_taken",    1, 4'h7, 4'h1, 0, 0, 0,             1, 64'd0,  1, 3'b010, 0, 0));
    tbl.push_back(mk("jg_not",       1, 4'h7, 4'h6, 0, 0, 0,             1, 64'd0,  0, 3'b010, 0, 0));
    tbl.push_back(mk("jmp",          1, 4'h7, 4'h0, 0, 0, 0,             1, 64'd0,  1, 3'b010, 0, 0));
    tbl.push_back(mk("sub_ovf",      1, 4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 0, 1, MAXP, 0, 3'b001, 0, 0));
    tbl.push_back(mk("jge_not",      1, 4'h7, 4'h5, 0, 0, 0,             1, 64'd0,  0, 3'b001, 0, 0));
    tbl.push_back(mk("jl_taken",     1, 4'h7, 4'h2, 0, 0, 0,             1, 64'd0,  1, 3'b001, 0, 0));
    tbl.push_back(mk("bubble_hold1", 0, 4'h6, 4'h0, 64'd3, 64'd3, 0,     0, 64'd0,  1, 3'b001, 0, 0));
    tbl.push_back(mk("call",         1, 4'h8, 4'h0, 0, 64'h200, 0,       1, 64'h1F8,0, 3'b001, 0, 0));
    tbl.push_back(mk("ret",          1, 4'h9, 4'h0, 0, 64'd0, 0,         1, 64'd8,  0, 3'b001, 0, 0));
    tbl.push_back(mk("bubble_hold2", 0, 4'h3, 4'h0, 0, 0, 64'd77,        0, 64'd8,  0, 3'b001, 0, 0));
    tbl.push_back(mk("nop",          1, 4'h1, 4'h0, 64'd5, 64'd5, 64'd5, 1, 64'd0,  0, 3'b001, 0, 0));
    tbl.push_back(mk("rrmovq",       1, 4'h2, 4'h0, 64'hDEAD, 0, 0,      1, 64'hDEAD,1, 3'b001, 0, 0));

    $display("[TB] reset checks");
    applyStimulus(mk("reset_wins", 1, 4'h6, 4'h1, 64'd1, 64'd0, 0, 0, 64'd0, 0, 3'b100, 0, 0), 1'b1);
    checkOutput();
    applyStimulus(mk("reset_idle", 0, 4'h0, 4'h0, 0, 0, 0, 0, 64'd0, 0, 3'b100, 0, 0), 1'b1);
    checkOutput();

    $display("[TB] vector table");
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i], 1'b0);
      checkOutput();
    end

    $display("[TB] halt sequence");
    applyStimulus(mk("halt",         1, 4'h0, 4'h0, 0, 0, 0,         1, 64'd0, 0, 3'b001, 0, 1), 1'b0);
    checkOutput();
    applyStimulus(mk("after_halt",   1, 4'h6, 4'h0, 64'd1, 64'd1, 0, 0, 64'd0, 0, 3'b001, 0, 1), 1'b0);
    checkOutput();
    applyStimulus(mk("still_halted", 1, 4'h3, 4'h0, 0, 0, 64'd9,     0, 64'd0, 0, 3'b001, 0, 1), 1'b0);
    checkOutput();
    applyStimulus(mk("reset_clears", 0, 4'h0, 4'h0, 0, 0, 0,         0, 64'd0, 0, 3'b100, 0, 0), 1'b1);
    checkOutput();

    $display("[TB] invalid instruction sequence");
    applyStimulus(mk("irmovq_55",    1, 4'h3, 4'h0, 0, 0, 64'd55,    1, 64'd55, 0, 3'b100, 0, 0), 1'b0);
    checkOutput();
    applyStimulus(mk("opq_ifun4",    1, 4'h6, 4'h4, 64'd1, 64'd2, 0, 1, 64'd0,  0, 3'b100, 1, 1), 1'b0);
    checkOutput();
    applyStimulus(mk("err_pulse",    1, 4'h6, 4'h0, 64'd1, 64'd1, 0, 0, 64'd0,  0, 3'b100, 0, 1), 1'b0);
    checkOutput();
    applyStimulus(mk("reset_drop",   1, 4'h6, 4'h1, 64'd1, 64'd0, 0, 0, 64'd0,  0, 3'b100, 0, 0), 1'b1);
    checkOutput();

    bad.push_back(mk("bad_icode_C",  1, 4'hC, 4'h0, 0, 0, 0, 1, 64'd0, 0, 3'b100, 1, 1));
    bad.push_back(mk("bad_icode_F",  1, 4'hF, 4'h0, 0, 0, 0, 1, 64'd0, 0, 3'b100, 1, 1));
    bad.push_back(mk("bad_cmov_f7",  1, 4'h2, 4'h7, 64'd4, 0, 0, 1, 64'd0, 0, 3'b100, 1, 1));
    bad.push_back(mk("bad_jxx_fF",   1, 4'h7, 4'hF, 0, 0, 0, 1, 64'd0, 0, 3'b100, 1, 1));
    bad.push_back(mk("bad_irmov_f1", 1, 4'h3, 4'h1, 0, 0, 64'd3, 1, 64'd0, 0, 3'b100, 1, 1));
    bad.push_back(mk("bad_push_f1",  1, 4'hA, 4'h1, 0, 64'h40, 0, 1, 64'd0, 0, 3'b100, 1, 1));
    bad.push_back(mk("bad_halt_f1",  1, 4'h0, 4'h1, 0, 0, 0, 1, 64'd0, 0, 3'b100, 1, 1));
    for (int i = 0; i < bad.size(); i++) begin
      applyStimulus(bad[i], 1'b0);
      checkOutput();
      applyStimulus(mk("reset_after_bad", 0, 4'h0, 4'h0, 0, 0, 0, 0, 64'd0, 0, 3'b100, 0, 0), 1'b1);
      checkOutput();
    end

    reset        = 1'b0;
    bus.in_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Y86-64 execute stage. Sits directly downstream of decode.
- Consumes icode/ifun from fetch, and valA/valB/valC from fetch/decode.
- Produces valE for memory/write-back, plus the branch/cmov condition Cnd.
- Owns the architectural condition-code register (ZF, SF, OF) and a sticky halted status. All outputs are registered, with one-cycle latency.

Parameters:
- STACK_STEP, 8: byte adjustment applied to the stack pointer by call/push/ret/pop.
- CC_RESET, 3'b100: reset value of {ZF,SF,OF}.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: icode/ifun/valA/valB/valC are valid this cycle.
- icode, input, 4: instruction code.
- ifun, input, 4: function code.
- valA, input, 64: decoded rA operand.
- valB, input, 64: decoded rB operand (%rsp for stack ops).
- valC, input, 64: constant word.
- out_valid, output, 1: registered outputs correspond to an accepted instruction.
- valE, output, 64: ALU result.
- Cnd, output, 1: condition result for jXX/cmovXX.
- ZF, output, 1: zero flag (current CC state).
- SF, output, 1: sign flag (current CC state).
- OF, output, 1: overflow flag (current CC state).
- instr_err, output, 1: accepted instruction had an invalid icode/ifun.
- halted, output, 1: sticky; set by halt or an error.

Behaviour:
- Reset (sampled at the clk edge):
  - out_valid=0, valE=0, Cnd=0, instr_err=0, halted=0.
  - {ZF,SF,OF}=CC_RESET.
  - Reset wins over any same-cycle input. An in-flight instruction is discarded.
- Accept rule: an instruction is accepted when in_valid=1 and halted=0. Accepted means that on the next edge out_valid=1 and valE/Cnd/instr_err are updated.
- When not accepted:
  - out_valid=0 and instr_err=0.
  - valE and Cnd hold their values.
  - CC is unchanged.
- valE by icode (64-bit two's-complement, wrap modulo 2^64):
  - 0 halt, 1 nop, 7 jXX: 0.
  - 2 rrmovq/cmovXX: valA.
  - 3 irmovq: valC.
  - 4 rmmovq, 5 mrmovq: valB+valC.
  - 6 OPq: ifun 0 gives valB+valA; ifun 1 gives valB-valA; ifun 2 gives valB&valA; ifun 3 gives valB^valA.
  - 8 call, A pushq: valB-STACK_STEP.
  - 9 ret, B popq: valB+STACK_STEP.
- CC update: only for an accepted, valid OPq. Written at the same edge as valE.
  - ZF = (result==0).
  - SF = result[63].
  - OF for add: operands share a sign and the result sign differs.
  - OF for sub: valB and valA signs differ and the result sign differs from valB.
  - OF for and/xor: 0.
- Cnd: evaluated for icode 2 and 7 from the CC state held before this instruction (a preceding OPq's update is visible the very next cycle; no bypass needed).
  - ifun 0 always: 1.
  - ifun 1 le: (SF^OF)|ZF.
  - ifun 2 l: SF^OF.
  - ifun 3 e: ZF.
  - ifun 4 ne: ~ZF.
  - ifun 5 ge: ~(SF^OF).
  - ifun 6 g: ~(SF^OF)&~ZF.
  - All other icodes: Cnd=0.
- Invalid instructions: icode>4'hB; OPq with ifun>3; icode 2/7 with ifun>6; any other icode with ifun!=0.
  - Response: out_valid=1, instr_err=1 (one-cycle pulse), valE=0, Cnd=0.
  - CC unchanged; halted set at the same edge.
- Halt: accepted icode 0 produces out_valid=1 with valE=0 and sets halted at the same edge.
  - Afterwards every in_valid is ignored until reset.
  - halted clears only on reset.
- Back-to-back operation: an instruction may be accepted every cycle. There is no backpressure.

Test Plan:
- Reset, then OPq add (ifun 0) with valA=5, valB=7 -> next cycle: out_valid=1, valE=12, ZF=0, SF=0, OF=0.
- OPq sub with valA=7, valB=7, then next cycle jXX ifun 3 (je) -> valE=0, ZF=1, then Cnd=1. Follow with jne (ifun 4) -> Cnd=0, valE=0.
- OPq add with valA=valB=64'h7FFF_FFFF_FFFF_FFFF -> valE=64'hFFFF_FFFF_FFFF_FFFE, ZF=0, SF=1, OF=1. Then jl (ifun 2) -> Cnd=0; cmovge (icode 2, ifun 5) with valA=9 -> valE=9, Cnd=1.
- pushq with valB=64'h100 -> valE=64'hF8; then popq with valB=64'hF8 -> valE=64'h100; irmovq with valC=42 -> valE=42; CC unchanged throughout.
- halt, then OPq with in_valid=1 -> halt cycle out_valid=1, valE=0, halted=1. The next cycle has out_valid=0 with CC and valE held. Asserting reset -> halted=0, {ZF,SF,OF}=100.
- OPq with ifun=4 -> out_valid=1, instr_err=1, valE=0, halted=1, CC unchanged. Asserting reset in the same cycle as a valid OPq -> that OPq is dropped and out_valid=0.
